// File: rtl/matrix_loader.sv
// matrix_loader: assembles a stream of ELEM_W-bit elements into 4x4 matrices.
// The matrices are held in two ping-pong buffers. The loader accepts new elements while
// the downstream consumer works through completed matrices.
// Optional feature: define MATRIX_LOADER_TRANSPOSE_EN to store column-major input row-major.
module matrix_loader #(
    parameter int unsigned ELEM_W = 16,
    parameter int unsigned N_ELEM = 16
) (
    input  logic                     CLK,
    input  logic                     reset,
    input  logic [ELEM_W-1:0]        elem_in,
    input  logic                     elem_valid,
    input  logic                     elem_last,
    input  logic [3:0]               op_in,
    output logic                     elem_ready,
    output logic [ELEM_W*N_ELEM-1:0] Matrix_in,
    output logic [3:0]               command,
    output logic                     mat_valid,
    input  logic                     mat_ready,
    output logic [1:0]               fill_level,
    output logic                     short_flag
);

    localparam int unsigned MAT_W = ELEM_W * N_ELEM;
    localparam int unsigned IDX_W = $clog2(N_ELEM);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ELEM - 1);

    // Ping-pong matrix storage and the command captured with each matrix.
    logic [MAT_W-1:0] buf_q [2];
    logic [MAT_W-1:0] buf_d [2];
    logic [3:0]       cmd_q [2];
    logic [3:0]       cmd_d [2];

    logic             wr_sel_q, wr_sel_d;
    logic             rd_sel_q, rd_sel_d;
    logic [1:0]       count_q, count_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             short_q, short_d;
    // Held low through reset so elem_ready only rises on the first edge after release.
    logic             ready_q;

    logic             accept;
    logic             consume;
    logic             complete;
    logic [IDX_W-1:0] slot;

    // Map the incoming element index to its storage slot.
`ifdef MATRIX_LOADER_TRANSPOSE_EN
    // Column-major input: element i lands at row (i mod 4), column (i div 4).
    assign slot = {idx_q[1:0], idx_q[3:2]};
`else
    assign slot = idx_q;
`endif

    // Handshake qualifiers for the write and read sides.
    always_comb begin
        elem_ready = ready_q && (count_q != 2'd2);
        mat_valid  = (count_q != 2'd0);
        accept     = elem_valid && elem_ready;
        consume    = mat_valid && mat_ready;
        complete   = accept && (elem_last || (idx_q == LAST_IDX));
    end

    // Next-state logic: element write, pointer toggles and occupancy count.
    always_comb begin
        buf_d    = buf_q;
        cmd_d    = cmd_q;
        wr_sel_d = wr_sel_q;
        rd_sel_d = rd_sel_q;
        count_d  = count_q;
        idx_d    = idx_q;
        short_d  = 1'b0;

        if (accept) begin
            // Starting a matrix wipes stale data so a short matrix ends in zeros.
            if (idx_q == '0) begin
                buf_d[wr_sel_q] = '0;
                cmd_d[wr_sel_q] = op_in;
            end
            for (int unsigned s = 0; s < N_ELEM; s++) begin
                if (slot == IDX_W'(s)) begin
                    buf_d[wr_sel_q][s*ELEM_W +: ELEM_W] = elem_in;
                end
            end
            if (complete) begin
                idx_d    = '0;
                wr_sel_d = ~wr_sel_q;
                short_d  = elem_last && (idx_q != LAST_IDX);
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end

        if (consume) begin
            rd_sel_d = ~rd_sel_q;
        end

        unique case ({complete, consume})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // State registers; an asynchronous reset discards partial and held matrices alike.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            buf_q    <= '{default: '0};
            cmd_q    <= '{default: '0};
            wr_sel_q <= 1'b0;
            rd_sel_q <= 1'b0;
            count_q  <= 2'd0;
            idx_q    <= '0;
            short_q  <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            buf_q    <= buf_d;
            cmd_q    <= cmd_d;
            wr_sel_q <= wr_sel_d;
            rd_sel_q <= rd_sel_d;
            count_q  <= count_d;
            idx_q    <= idx_d;
            short_q  <= short_d;
            ready_q  <= 1'b1;
        end
    end

    // Present only completed matrices; the fill buffer stays hidden while nothing is valid.
    always_comb begin
        Matrix_in  = mat_valid ? buf_q[rd_sel_q] : '0;
        command    = mat_valid ? cmd_q[rd_sel_q] : 4'h0;
        fill_level = count_q;
        short_flag = short_q;
    end

endmodule

// File: tb/tb_matrix_loader.sv
// Directed self-checking bench for matrix_loader (default 16-bit, 16-element build).
module tb_matrix_loader;

    localparam int unsigned ELEM_W = 16;
    localparam int unsigned N_ELEM = 16;
    localparam int unsigned MAT_W  = ELEM_W * N_ELEM;

    logic              CLK;
    logic              reset;
    logic [ELEM_W-1:0] elem_in;
    logic              elem_valid;
    logic              elem_last;
    logic [3:0]        op_in;
    logic              elem_ready;
    logic [MAT_W-1:0]  Matrix_in;
    logic [3:0]        command;
    logic              mat_valid;
    logic              mat_ready;
    logic [1:0]        fill_level;
    logic              short_flag;

    int n_cmp = 0;
    int n_err = 0;

    matrix_loader #(
        .ELEM_W(ELEM_W),
        .N_ELEM(N_ELEM)
    ) dut (
        .CLK        (CLK),
        .reset      (reset),
        .elem_in    (elem_in),
        .elem_valid (elem_valid),
        .elem_last  (elem_last),
        .op_in      (op_in),
        .elem_ready (elem_ready),
        .Matrix_in  (Matrix_in),
        .command    (command),
        .mat_valid  (mat_valid),
        .mat_ready  (mat_ready),
        .fill_level (fill_level),
        .short_flag (short_flag)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check_eq(input string tag, input logic [MAT_W-1:0] got,
                            input logic [MAT_W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Storage slot of stream element i.
    function automatic int slot_of(input int i);
`ifdef MATRIX_LOADER_TRANSPOSE_EN
        return 4 * (i % 4) + (i / 4);
`else
        return i;
`endif
    endfunction

    // Expected matrix: element i = first + step*i for i < n, zeros elsewhere.
    function automatic logic [MAT_W-1:0] mat_of(input logic [15:0] first, input logic [15:0] step,
                                                input int n);
        logic [MAT_W-1:0] m;
        m = '0;
        for (int i = 0; i < n; i++) begin
            m[slot_of(i)*ELEM_W +: ELEM_W] = first + step * 16'(i);
        end
        return m;
    endfunction

    // Called at a falling edge; returns at the falling edge after the element is accepted.
    task automatic push(input logic [15:0] data, input logic last, input logic [3:0] op);
        int t;
        t          = 0;
        elem_in    = data;
        elem_last  = last;
        op_in      = op;
        elem_valid = 1'b1;
        while (!elem_ready && t < 100) begin
            @(negedge CLK);
            t++;
        end
        if (!elem_ready) check_eq("push_timeout", {255'b0, elem_ready}, 256'd1);
        @(negedge CLK);
        elem_valid = 1'b0;
        elem_last  = 1'b0;
    endtask

    initial begin
        reset      = 1'b0;
        elem_in    = '0;
        elem_valid = 1'b0;
        elem_last  = 1'b0;
        op_in      = '0;
        mat_ready  = 1'b0;

        // Reset state
        @(negedge CLK);
        check_eq("rst_ready", {255'b0, elem_ready}, 256'd0);
        check_eq("rst_valid", {255'b0, mat_valid}, 256'd0);
        check_eq("rst_fill", {254'b0, fill_level}, 256'd0);
        check_eq("rst_matrix", Matrix_in, 256'd0);
        check_eq("rst_cmd", {252'b0, command}, 256'd0);
        check_eq("rst_short", {255'b0, short_flag}, 256'd0);
        reset = 1'b1;
        #1 check_eq("ready_before_edge", {255'b0, elem_ready}, 256'd0);
        @(negedge CLK);
        check_eq("ready_after_edge", {255'b0, elem_ready}, 256'd1);

        // Basic load
        mat_ready = 1'b1;
        for (int k = 1; k <= 16; k++) push(16'(k), 1'b0, 4'h2);
        check_eq("basic_valid", {255'b0, mat_valid}, 256'd1);
        check_eq("basic_e0", {240'b0, Matrix_in[15:0]}, 256'h0001);
        check_eq("basic_e15", {240'b0, Matrix_in[255:240]}, 256'h0010);
`ifdef MATRIX_LOADER_TRANSPOSE_EN
        check_eq("basic_s7", {240'b0, Matrix_in[127:112]}, 256'h000e);
`else
        check_eq("basic_s7", {240'b0, Matrix_in[127:112]}, 256'h0008);
`endif
        check_eq("basic_full", Matrix_in, mat_of(16'h0001, 16'h0001, 16));
        check_eq("basic_cmd", {252'b0, command}, 256'h2);
        @(negedge CLK);
        check_eq("basic_drained", {255'b0, mat_valid}, 256'd0);
        mat_ready = 1'b0;

        // Backpressure: 32 elements fill both buffers
        for (int k = 1; k <= 32; k++) push(16'h0100 + 16'(k), 1'b0, (k <= 16) ? 4'h5 : 4'h6);
        check_eq("bp_fill2", {254'b0, fill_level}, 256'd2);
        check_eq("bp_ready0", {255'b0, elem_ready}, 256'd0);
        elem_in    = 16'h0121;
        op_in      = 4'h7;
        elem_valid = 1'b1;
        repeat (3) @(negedge CLK);
        check_eq("bp_still_blocked", {255'b0, elem_ready}, 256'd0);
        check_eq("bp_hold_fill", {254'b0, fill_level}, 256'd2);
        check_eq("bp_stable_m1", Matrix_in, mat_of(16'h0101, 16'h0001, 16));
        check_eq("bp_cmd_m1", {252'b0, command}, 256'h5);
        mat_ready = 1'b1;
        @(negedge CLK);
        mat_ready = 1'b0;
        check_eq("bp_fill1", {254'b0, fill_level}, 256'd1);
        check_eq("bp_ready1", {255'b0, elem_ready}, 256'd1);
        check_eq("bp_m2_e0", {240'b0, Matrix_in[15:0]}, 256'h0111);
        for (int k = 33; k <= 48; k++) push(16'h0100 + 16'(k), 1'b0, 4'h7);
        check_eq("bp_fill2_again", {254'b0, fill_level}, 256'd2);
        mat_ready = 1'b1;
        check_eq("bp_m2_full", Matrix_in, mat_of(16'h0111, 16'h0001, 16));
        check_eq("bp_cmd_m2", {252'b0, command}, 256'h6);
        @(negedge CLK);
        check_eq("bp_m3_full", Matrix_in, mat_of(16'h0121, 16'h0001, 16));
        check_eq("bp_m3_e15", {240'b0, Matrix_in[255:240]}, 256'h0130);
        check_eq("bp_cmd_m3", {252'b0, command}, 256'h7);
        @(negedge CLK);
        check_eq("bp_empty", {254'b0, fill_level}, 256'd0);
        mat_ready = 1'b0;

        // Short matrix lands in the buffer that held m2
        for (int k = 1; k <= 5; k++) push(16'hAAAA, (k == 5), 4'h3);
        check_eq("short_pulse", {255'b0, short_flag}, 256'd1);
        check_eq("short_valid", {255'b0, mat_valid}, 256'd1);
        check_eq("short_e0", {240'b0, Matrix_in[15:0]}, 256'hAAAA);
        check_eq("short_matrix", Matrix_in, mat_of(16'hAAAA, 16'h0000, 5));
        @(negedge CLK);
        check_eq("short_pulse_end", {255'b0, short_flag}, 256'd0);
        mat_ready = 1'b1;
        @(negedge CLK);
        mat_ready = 1'b0;
        check_eq("short_drained", {255'b0, mat_valid}, 256'd0);

        // Simultaneous completion and consumption
        for (int k = 0; k < 16; k++) push(16'h0201 + 16'(k), 1'b0, 4'h8);
        for (int k = 0; k < 15; k++) push(16'h0301 + 16'(k), 1'b0, 4'h9);
        mat_ready = 1'b1;
        push(16'h0310, 1'b0, 4'h9);
        mat_ready = 1'b0;
        check_eq("sim_fill", {254'b0, fill_level}, 256'd1);
        check_eq("sim_new_matrix", Matrix_in, mat_of(16'h0301, 16'h0001, 16));
        check_eq("sim_cmd", {252'b0, command}, 256'h9);
        check_eq("sim_short_quiet", {255'b0, short_flag}, 256'd0);

        // Mid-operation reset with one held matrix and a partial one
        for (int k = 0; k < 7; k++) push(16'h0401 + 16'(k), 1'b0, 4'hA);
        reset = 1'b0;
        #1;
        check_eq("mrst_valid", {255'b0, mat_valid}, 256'd0);
        check_eq("mrst_fill", {254'b0, fill_level}, 256'd0);
        check_eq("mrst_ready", {255'b0, elem_ready}, 256'd0);
        check_eq("mrst_matrix", Matrix_in, 256'd0);
        @(negedge CLK);
        reset = 1'b1;
        @(negedge CLK);
        for (int k = 0; k < 16; k++) push(16'h0501 + 16'(k), 1'b0, 4'hB);
        check_eq("mrst_fill_new", {254'b0, fill_level}, 256'd1);
        check_eq("mrst_new_matrix", Matrix_in, mat_of(16'h0501, 16'h0001, 16));
        check_eq("mrst_cmd", {252'b0, command}, 256'hB);
        mat_ready = 1'b1;
        @(negedge CLK);
        mat_ready = 1'b0;
        check_eq("mrst_drained", {255'b0, mat_valid}, 256'd0);

        // Slot placement with values 0..15
        for (int k = 0; k < 16; k++) push(16'(k), 1'b0, 4'h1);
`ifdef MATRIX_LOADER_TRANSPOSE_EN
        check_eq("place_s1", {240'b0, Matrix_in[31:16]}, 256'd4);
        check_eq("place_s4", {240'b0, Matrix_in[79:64]}, 256'd1);
`else
        check_eq("place_s1", {240'b0, Matrix_in[31:16]}, 256'd1);
        check_eq("place_s4", {240'b0, Matrix_in[79:64]}, 256'd4);
`endif
        check_eq("place_full", Matrix_in, mat_of(16'h0000, 16'h0001, 16));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
